// File: rtl/scc_vector_checker.sv
// scc_vector_checker
// Stimulus/check harness for the SCC core. Holds DEPTH instruction/expected
// pairs, issues them in order over a valid/ready handshake, compares every
// returned result and reports pass/fail counts, first failing index and a
// sticky timeout flag for the run.
// Build option: define SCC_CHK_MASK_EN to add the load_mask port and a
// per-slot compare mask (mask bit 0 = don't care).
module scc_vector_checker #(
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 16,
  parameter int ADDR_W  = $clog2(DEPTH),
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_instr,
  input  logic [DATA_W-1:0] load_expect,
`ifdef SCC_CHK_MASK_EN
  input  logic [DATA_W-1:0] load_mask,
`endif
  input  logic              start,
  input  logic [ADDR_W:0]   num_vec,
  output logic [DATA_W-1:0] instruction,
  output logic              instr_valid,
  input  logic              instr_ready,
  input  logic [DATA_W-1:0] results,
  input  logic              result_valid,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   pass_cnt,
  output logic [ADDR_W:0]   fail_cnt,
  output logic [ADDR_W-1:0] first_fail,
  output logic              timeout
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  localparam int              WAIT_W    = $clog2(TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);
  localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] CNT_ONE   = (ADDR_W+1)'(1);

  logic [DATA_W-1:0] mem_instr  [DEPTH];
  logic [DATA_W-1:0] mem_expect [DEPTH];
`ifdef SCC_CHK_MASK_EN
  logic [DATA_W-1:0] mem_mask   [DEPTH];
`endif

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [ADDR_W:0]   num_q, num_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic              valid_q, valid_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [ADDR_W:0]   pass_q, pass_d;
  logic [ADDR_W:0]   fail_q, fail_d;
  logic [ADDR_W-1:0] ffail_q, ffail_d;
  logic              tout_q, tout_d;

  logic              ctrl_free;
  logic              load_ok;
  logic              start_ok;
  logic [ADDR_W:0]   num_clamp;
  logic [DATA_W-1:0] cmp_mask;
  logic [DATA_W-1:0] slot0_instr;
  logic              last_vec;
  logic              vec_end;
  logic              vec_fail;

  // Masked equality: only bits set in the mask take part in the compare.
  function automatic logic vec_match(input logic [DATA_W-1:0] res_v,
                                     input logic [DATA_W-1:0] exp_v,
                                     input logic [DATA_W-1:0] msk_v);
    return ((res_v ^ exp_v) & msk_v) == '0;
  endfunction

  assign ctrl_free = (state_q == S_IDLE) || (state_q == S_DONE);
  assign load_ok   = load_en && ctrl_free;
  assign start_ok  = start && ctrl_free;
  assign num_clamp = (num_vec > DEPTH_CNT) ? DEPTH_CNT : num_vec;
  assign last_vec  = ({1'b0, idx_q} == (num_q - CNT_ONE));
  // A load in the start cycle must be seen by the first issued instruction.
  assign slot0_instr = (load_ok && (load_addr == '0)) ? load_instr : mem_instr[0];

`ifdef SCC_CHK_MASK_EN
  assign cmp_mask = mem_mask[idx_q];
`else
  assign cmp_mask = '1;
`endif

  // Vector memory: written only while no run is active; contents survive reset.
  always_ff @(posedge clk) begin
    if (load_ok) begin
      mem_instr[load_addr]  <= load_instr;
      mem_expect[load_addr] <= load_expect;
`ifdef SCC_CHK_MASK_EN
      mem_mask[load_addr]   <= load_mask;
`endif
    end
  end

  // Next-state and next-output logic for the run sequencer.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    num_d    = num_q;
    wait_d   = wait_q;
    instr_d  = instr_q;
    valid_d  = valid_q;
    busy_d   = busy_q;
    done_d   = done_q;
    pass_d   = pass_q;
    fail_d   = fail_q;
    ffail_d  = ffail_q;
    tout_d   = tout_q;
    vec_end  = 1'b0;
    vec_fail = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_ok) begin
          pass_d  = '0;
          fail_d  = '0;
          ffail_d = '0;
          tout_d  = 1'b0;
          idx_d   = '0;
          num_d   = num_clamp;
          if (num_clamp == '0) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            valid_d = 1'b0;
          end else begin
            state_d = S_ISSUE;
            done_d  = 1'b0;
            busy_d  = 1'b1;
            valid_d = 1'b1;
            instr_d = slot0_instr;
          end
        end
      end
      S_ISSUE: begin
        if (instr_ready) begin
          state_d = S_WAIT;
          valid_d = 1'b0;
          wait_d  = '0;
        end
      end
      S_WAIT: begin
        if (result_valid) begin
          vec_end  = 1'b1;
          vec_fail = !vec_match(results, mem_expect[idx_q], cmp_mask);
        end else if (wait_q == WAIT_LAST) begin
          vec_end  = 1'b1;
          vec_fail = 1'b1;
          tout_d   = 1'b1;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
        if (vec_end) begin
          if (vec_fail) begin
            fail_d = fail_q + CNT_ONE;
            if (fail_q == '0) ffail_d = idx_q;
          end else begin
            pass_d = pass_q + CNT_ONE;
          end
          if (last_vec) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
          end else begin
            // Next vector is presented immediately, no idle cycle in between.
            idx_d   = idx_q + ADDR_W'(1);
            state_d = S_ISSUE;
            valid_d = 1'b1;
            instr_d = mem_instr[idx_q + ADDR_W'(1)];
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Sequencer state and registered outputs; reset drops them immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      num_q   <= '0;
      wait_q  <= '0;
      instr_q <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= '0;
      fail_q  <= '0;
      ffail_q <= '0;
      tout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      num_q   <= num_d;
      wait_q  <= wait_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      fail_q  <= fail_d;
      ffail_q <= ffail_d;
      tout_q  <= tout_d;
    end
  end

  assign instruction = instr_q;
  assign instr_valid = valid_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign pass_cnt    = pass_q;
  assign fail_cnt    = fail_q;
  assign first_fail  = ffail_q;
  assign timeout     = tout_q;

endmodule

// File: tb/tb_scc_vector_checker.sv
// tb_scc_vector_checker: directed vectors against a small SCC model; a
// scoreboard queue holds expected instructions and end-of-run statistics,
// and a monitor process pops and compares them as the DUT presents them.
`timescale 1ns/1ps
module tb_scc_vector_checker;

  localparam int DATA_W  = 32;
  localparam int DEPTH   = 16;
  localparam int ADDR_W  = 4;
  localparam int TIMEOUT = 64;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              load_en = 1'b0;
  logic [ADDR_W-1:0] load_addr = '0;
  logic [DATA_W-1:0] load_instr = '0;
  logic [DATA_W-1:0] load_expect = '0;
`ifdef SCC_CHK_MASK_EN
  logic [DATA_W-1:0] load_mask = '1;
`endif
  logic              start = 1'b0;
  logic [ADDR_W:0]   num_vec = '0;
  logic [DATA_W-1:0] instruction;
  logic              instr_valid;
  logic              instr_ready = 1'b0;
  logic [DATA_W-1:0] results = '0;
  logic              result_valid = 1'b0;
  logic              busy;
  logic              done;
  logic [ADDR_W:0]   pass_cnt;
  logic [ADDR_W:0]   fail_cnt;
  logic [ADDR_W-1:0] first_fail;
  logic              timeout;

  scc_vector_checker #(.DATA_W(DATA_W), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .load_en(load_en), .load_addr(load_addr),
    .load_instr(load_instr), .load_expect(load_expect),
`ifdef SCC_CHK_MASK_EN
    .load_mask(load_mask),
`endif
    .start(start), .num_vec(num_vec), .instruction(instruction),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .results(results),
    .result_valid(result_valid), .busy(busy), .done(done), .pass_cnt(pass_cnt),
    .fail_cnt(fail_cnt), .first_fail(first_fail), .timeout(timeout)
  );

  always #5 clk = ~clk;

  typedef struct { int p; int f; int ff; int to; } sum_t;

  int          n_chk = 0;
  int          n_fail = 0;
  logic [31:0] exp_instr [$];
  sum_t        exp_sum [$];
  int          hs_cyc [$];
  int          cyc = 0;
  logic [31:0] tb_instr [DEPTH];
  logic [31:0] tb_exp [DEPTH];

  // SCC model controls
  int          vec_no = 0;
  int          bad_idx = -1;
  int          drop_idx = -1;
  int          stall_left = 0;
  logic [31:0] bad_val = '0;
  bit          model_hs;
  bit          done_prev = 0;
  bit          stall_prev = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  task automatic fail_now(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s: event with no expected entry", name);
  endtask

  // SCC model: replies one cycle after each handshake, unless told to drop it.
  initial begin
    forever begin
      @(negedge clk);
      model_hs = instr_valid && instr_ready && !reset;
      @(posedge clk);
      #1;
      result_valid = 1'b0;
      if (model_hs) begin
        if (vec_no != drop_idx) begin
          result_valid = 1'b1;
          results = (vec_no == bad_idx) ? bad_val : tb_exp[vec_no % DEPTH];
        end
        vec_no++;
      end
      if (stall_left > 0) begin
        instr_ready = 1'b0;
        stall_left--;
      end else begin
        instr_ready = 1'b1;
      end
    end
  end

  // Monitor: compares issued instructions and end-of-run statistics.
  initial begin
    sum_t        s;
    logic [31:0] e;
    forever begin
      @(negedge clk);
      cyc++;
      if (reset) begin
        done_prev  = 0;
        stall_prev = 0;
      end else begin
        if (stall_prev) check("valid_hold", instr_valid, 1);
        if (instr_valid && instr_ready) begin
          hs_cyc.push_back(cyc);
          if (exp_instr.size() == 0) fail_now("instr_unexpected");
          else begin
            e = exp_instr.pop_front();
            check("instr", instruction, e);
          end
        end else if (instr_valid && exp_instr.size() != 0) begin
          check("instr_hold", instruction, exp_instr[0]);
        end
        stall_prev = instr_valid && !instr_ready;
        if (done && !done_prev) begin
          if (exp_sum.size() == 0) fail_now("done_unexpected");
          else begin
            s = exp_sum.pop_front();
            check("pass_cnt", pass_cnt, s.p);
            check("fail_cnt", fail_cnt, s.f);
            check("first_fail", first_fail, s.ff);
            check("timeout", timeout, s.to);
            check("busy_at_done", busy, 0);
          end
        end
        done_prev = done;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic load_slot(input int i, input logic [31:0] ins, input logic [31:0] ex,
                           input logic [31:0] msk);
    tb_instr[i] = ins;
    tb_exp[i]   = ex;
    load_en     = 1'b1;
    load_addr   = ADDR_W'(i);
    load_instr  = ins;
    load_expect = ex;
`ifdef SCC_CHK_MASK_EN
    load_mask   = msk;
`else
    if (msk == '0) load_instr = ins;
`endif
    @(posedge clk);
    #1;
    load_en = 1'b0;
  endtask

  task automatic launch_run(input int n, input int ep, input int ef, input int eff,
                            input int eto, input int bad, input logic [31:0] bval,
                            input int drop, input int stall, input bit busy_load);
    sum_t s;
    int   m;
    m = (n > DEPTH) ? DEPTH : n;
    bad_idx = bad; bad_val = bval; drop_idx = drop; stall_left = stall; vec_no = 0;
    hs_cyc.delete();
    for (int i = 0; i < m; i++) exp_instr.push_back(tb_instr[i]);
    s.p = ep; s.f = ef; s.ff = eff; s.to = eto;
    exp_sum.push_back(s);
    num_vec = (ADDR_W+1)'(n);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    if (busy_load) begin
      load_en = 1'b1; load_addr = 3; load_instr = 32'hBAD0BAD0; load_expect = 32'hBAD1BAD1;
      @(posedge clk);
      #1;
      load_en = 1'b0;
    end
  endtask

  task automatic wait_done(input string tag);
    int k = 0;
    while (!done && k < 3000) begin
      @(posedge clk);
      #1;
      k++;
    end
    check({tag, "_done"}, done, 1);
    @(negedge clk);
    @(posedge clk);
    #1;
    check({tag, "_sb_empty"}, exp_sum.size() + exp_instr.size(), 0);
    exp_sum.delete();
    exp_instr.delete();
  endtask

  initial begin
    sum_t s;
    int   k;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    // reset state
    check("rst_instr", instruction, 0);
    check("rst_valid", instr_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_pass", pass_cnt, 0);
    check("rst_fail", fail_cnt, 0);
    check("rst_ff", first_fail, 0);
    check("rst_timeout", timeout, 0);

    for (int i = 0; i < 4; i++)
      load_slot(i, 32'(i + 1), 32'((i + 1) * 17), '1);

    // all four pass, back-to-back issue
    launch_run(4, 4, 0, 0, 0, -1, '0, -1, 0, 0);
    wait_done("basic");
    check("basic_hs_count", hs_cyc.size(), 4);
    check("basic_gap", hs_cyc[1] - hs_cyc[0], 2);

    // vector 2 corrupted; a load attempted while busy must be ignored
    launch_run(4, 3, 1, 2, 0, 2, 32'hDEADBEEF, -1, 0, 1);
    wait_done("mismatch");

    // ready held low for 10 cycles on vector 0; slot 3 must still be intact
    launch_run(4, 4, 0, 0, 0, -1, '0, -1, 10, 0);
    wait_done("stall");
    check("stall_hs_count", hs_cyc.size(), 4);

    // vector 1 never answered: timeout after TIMEOUT wait cycles, run continues
    launch_run(4, 3, 1, 1, 1, -1, '0, 1, 0, 0);
    wait_done("tout");
    check("tout_gap", hs_cyc[2] - hs_cyc[1], TIMEOUT + 1);

    // zero-length run right after a failing run clears the statistics
    num_vec = '0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("zero_done", done, 1);
    check("zero_busy", busy, 0);
    check("zero_pass", pass_cnt, 0);
    check("zero_fail", fail_cnt, 0);
    check("zero_timeout", timeout, 0);

    // load and start in the same cycle: the run sees the new slot 0
    tb_instr[0] = 32'h55; tb_exp[0] = 32'h66;
    bad_idx = -1; drop_idx = -1; stall_left = 0; vec_no = 0;
    hs_cyc.delete();
    exp_instr.push_back(32'h55);
    s.p = 1; s.f = 0; s.ff = 0; s.to = 0;
    exp_sum.push_back(s);
    load_en = 1'b1; load_addr = '0; load_instr = 32'h55; load_expect = 32'h66;
    num_vec = 1; start = 1'b1;
    @(posedge clk);
    #1;
    load_en = 1'b0; start = 1'b0;
    wait_done("ldst");

    // reset asserted mid-WAIT of vector 2
    launch_run(4, 0, 0, 0, 0, -1, '0, 2, 0, 0);
    k = 0;
    while (hs_cyc.size() < 3 && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("rst_reach_v2", hs_cyc.size(), 3);
    repeat (3) @(negedge clk);
    check("pre_rst_busy", busy, 1);
    check("pre_rst_pass", pass_cnt, 2);
    #2;
    reset = 1'b1;
    #1;
    check("async_valid", instr_valid, 0);
    check("async_instr", instruction, 0);
    check("async_busy", busy, 0);
    check("async_done", done, 0);
    check("async_pass", pass_cnt, 0);
    check("async_fail", fail_cnt, 0);
    check("async_timeout", timeout, 0);
    exp_instr.delete();
    exp_sum.delete();
    @(posedge clk);
    #1;
    reset = 1'b0;

    // zero-length run from IDLE: done the next cycle
    s.p = 0; s.f = 0; s.ff = 0; s.to = 0;
    exp_sum.push_back(s);
    num_vec = '0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("idle_zero_done", done, 1);
    wait_done("idle_zero");

    // memory preserved across reset
    launch_run(4, 4, 0, 0, 0, -1, '0, -1, 0, 0);
    wait_done("post_rst");

    // all slots loaded, num_vec above DEPTH is clamped
    for (int i = 4; i < DEPTH; i++)
      load_slot(i, 32'h100 + 32'(i), 32'h1000 + 32'(i), '1);
    launch_run(20, DEPTH, 0, 0, 0, -1, '0, -1, 0, 0);
    wait_done("clamp");
    check("clamp_hs_count", hs_cyc.size(), DEPTH);

`ifdef SCC_CHK_MASK_EN
    // low half masked off: differing low half passes, differing high half fails
    load_slot(0, 32'h7, 32'h12340000, 32'hFFFF0000);
    launch_run(1, 1, 0, 0, 0, 0, 32'h1234ABCD, -1, 0, 0);
    wait_done("mask_pass");
    launch_run(1, 0, 1, 0, 0, 0, 32'h1235ABCD, -1, 0, 0);
    wait_done("mask_fail");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
